// File: rtl/dsp_mac_stream_driver_if.sv
// rtl/dsp_mac_stream_driver_if.sv - operand beat and vector result streams of the DSP MAC driver
// out_beats exists only when DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN is defined.
interface dsp_mac_stream_driver_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 27
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_ax;
  logic [DATA_W-1:0] in_ay;
  logic [DATA_W-1:0] in_bx;
  logic [DATA_W-1:0] in_by;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
`ifdef DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN
  logic [15:0]       out_beats;

  modport master (
    output in_valid, in_ax, in_ay, in_bx, in_by, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_beats
  );
  modport slave (
    input  in_valid, in_ax, in_ay, in_bx, in_by, in_last, out_ready,
    output in_ready, out_valid, out_result, out_beats
  );
`else
  modport master (
    output in_valid, in_ax, in_ay, in_bx, in_by, in_last, out_ready,
    input  in_ready, out_valid, out_result
  );
  modport slave (
    input  in_valid, in_ax, in_ay, in_bx, in_by, in_last, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/dsp_mac_stream_driver.sv
// rtl/dsp_mac_stream_driver.sv - sequences operand vectors into a dual-product DSP MAC and returns each sum
// Optional beat counter on out_beats: DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN.
module dsp_mac_stream_driver #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 27,
  parameter int MAC_LAT = 3
) (
  input  logic                  clk0,
  input  logic                  clr0,
  dsp_mac_stream_driver_if.slave s,
  output logic [DATA_W-1:0]     ax,
  output logic [DATA_W-1:0]     ay,
  output logic [DATA_W-1:0]     bx,
  output logic [DATA_W-1:0]     by,
  output logic                  accumulate,
  output logic [2:0]            ena,
  output logic                  mac_clr,
  input  logic [RES_W-1:0]      resulta,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(MAC_LAT - 1);

  state_t           state;
  logic [3:0]       drain_cnt;
  logic             clr_q;
  logic             acc;
  logic             out_valid_q;
  logic [RES_W-1:0] out_result_q;
`ifdef DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN
  logic [15:0]      beat_cnt;
  logic [15:0]      out_beats_q;

  assign s.out_beats = out_beats_q;
`endif

  assign s.in_ready   = !clr0 && (state == IDLE || state == STREAM);
  assign s.out_valid  = out_valid_q;
  assign s.out_result = out_result_q;
  assign acc          = s.in_valid && s.in_ready;
  assign busy         = (state != IDLE);
  // The MAC clear is stretched one cycle past reset so its pipeline is flushed.
  assign mac_clr      = clr0 || clr_q;

  always_comb begin
    ax         = '0;
    ay         = '0;
    bx         = '0;
    by         = '0;
    accumulate = 1'b1;
    ena        = 3'b000;
    if (acc) begin
      ax         = s.in_ax;
      ay         = s.in_ay;
      bx         = s.in_bx;
      by         = s.in_by;
      ena        = 3'b111;
      accumulate = (state != IDLE);
    end else if (state == DRAIN && !clr0) begin
      // Zero operands with accumulate set push the sum through unchanged.
      ena = 3'b111;
    end
  end

  always_ff @(posedge clk0) begin
    clr_q <= clr0;
    if (clr0) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifdef DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN
      beat_cnt     <= '0;
      out_beats_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE, STREAM: begin
          if (acc) begin
`ifdef DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN
            if (state == IDLE)
              beat_cnt <= 16'd1;
            else if (beat_cnt != 16'hFFFF)
              beat_cnt <= beat_cnt + 16'd1;
`endif
            if (s.in_last) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            out_result_q <= resulta;
            out_valid_q  <= 1'b1;
`ifdef DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN
            out_beats_q  <= beat_cnt;
`endif
            state        <= HOLD;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (s.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dsp_mac_stream_driver.md
Name: dsp_mac_stream_driver

Overview:
Initiator-side sequencer for the 8-bit dual-product DSP MAC (ax*ay + bx*by, accumulate, resulta).
- Accepts operand beats on a valid/ready stream, with in_last marking the end of each dot-product vector.
- Drives the MAC's operand, accumulate and ena pins, waits out the MAC pipeline, then captures resulta.
- Presents each vector's sum on a valid/ready result port. Sits between the BRAM operand fetch logic and one DSP MAC instance.

Parameters:
DATA_W, 8, operand width, signed two's complement
RES_W, 27, MAC result width
MAC_LAT, 3, enabled clock edges from operand presentation until resulta reflects that operand (1..15)

Ports:
clk0  in  1  single clock
clr0  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  driver accepts beat
in_ax, in_ay, in_bx, in_by  in  DATA_W each  operand beat
in_last  in  1  final beat of vector
ax, ay, bx, by  out  DATA_W each  to MAC
accumulate  out  1  to MAC; 0 = load, 1 = add to running sum
ena  out  3  to MAC clock enables, all bits equal
mac_clr  out  1  to MAC clr0/clr1
resulta  in  RES_W  from MAC
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  RES_W  captured vector sum
busy  out  1  high in any state except IDLE

Behaviour:
- Only clk0 is used; clr0 is synchronous and active-high.
- Handshakes:
  - Beat accepted (acc) when in_valid && in_ready.
  - Result transferred when out_valid && out_ready.
- FSM states: IDLE, STREAM, DRAIN, HOLD. Reset state is IDLE.
  - in_ready = 1 in IDLE/STREAM, 0 in DRAIN/HOLD.
  - IDLE: acc without in_last -> STREAM. acc with in_last -> DRAIN (single-beat vector).
  - STREAM: acc with in_last -> DRAIN. Otherwise stay.
  - DRAIN: 4-bit counter loaded with MAC_LAT-1 on entry, decrements each cycle. At 0: out_result <= resulta, out_valid <= 1, go to HOLD.
  - HOLD: out_valid = 1, out_result stable. On out_ready -> IDLE, out_valid <= 0 at the same edge.
- MAC drive (combinational from state and handshake):
  - acc cycle: ax/ay/bx/by = in_* ; ena = 3'b111 ; accumulate = 0 if state == IDLE, else 1.
  - DRAIN cycle: operands = 0, accumulate = 1, ena = 3'b111. The running sum is unchanged.
  - All other cycles: operands = 0, accumulate = 1, ena = 3'b000. The MAC pipeline freezes, so in_valid gaps mid-vector are harmless.
- Latency:
  - Last beat accepted in cycle T; DRAIN occupies cycles T+1..T+MAC_LAT.
  - Capture happens at the end of T+MAC_LAT; out_valid is high from cycle T+MAC_LAT+1.
  - Next vector's first beat is accepted no earlier than the cycle after the result transfer.
- Arithmetic:
  - out_result = sum over the vector of (ax*ay + bx*by), signed, modulo 2^RES_W (MAC wrap).
  - The driver performs no arithmetic.
- Reset:
  - Reset values: in_ready = 0, out_valid = 0, out_result = 0, busy = 0, ena = 0, accumulate = 1, operands = 0.
  - in_ready is 0 while clr0 is high.
  - mac_clr = 1 while clr0 is high and for one cycle after.
  - Reset mid-vector or mid-drain discards the vector; no result is emitted.
- Simultaneous in_valid in DRAIN/HOLD: ignored, in_ready = 0.
- out_ready with out_valid = 0: ignored.

Optional Feature:
Macro DSP_MAC_STREAM_DRIVER_BEAT_COUNT_EN.
- Defined:
  - Adds output out_beats (16 bits), the number of beats accepted in the vector, captured alongside out_result.
  - Count saturates at 16'hFFFF. Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- 3-beat vector (1,2,3,4), (5,6,7,8), (-1,1,0,0), MAC_LAT = 3, out_ready = 1 -> accumulate 0,1,1 on the beats; out_valid 4 cycles after the last beat; out_result = 99; beats = 3 if the macro is enabled.
- Single beat (-128,-128,-128,-128) -> accumulate = 0; out_result = 32768.
- Vector (2,3,0,0),(4,5,0,0) with in_valid low for 4 cycles between beats -> ena = 000 during the gap; out_result = 26.
- out_ready held low 5 cycles after out_valid -> out_result stable; in_ready = 0 throughout; an in_valid beat offered is not accepted; IDLE follows the transfer.
- clr0 pulsed after 2 beats of a vector, then vector (1,1,1,1) -> no stale result; mac_clr high 2 cycles; out_result = 2.
- Back-to-back vectors (10,10,0,0) then (1,1,0,0) -> results 100 then 1; the second vector's first beat has accumulate = 0.
